// File: rtl/mii_rx_pkg.sv
// Shared definitions for the MII receive MAC: FSM encoding, error bit
// positions, CRC-32 constants and MII nibble codes.
package mii_rx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PRE  = 2'd1,
      ST_DATA = 2'd2,
      ST_DROP = 2'd3
   } state_e;

   // Bit positions inside the 4-bit error word delivered with o_eof.
   localparam int ERR_CRC   = 0;
   localparam int ERR_RUNT  = 1;
   localparam int ERR_LONG  = 2;
   localparam int ERR_ALIGN = 3;

   // Reflected CRC-32 (IEEE 802.3).
   localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

   // Preamble and start-of-frame-delimiter nibbles as seen on MII.
   localparam logic [3:0] NIB_PRE = 4'h5;
   localparam logic [3:0] NIB_SFD = 4'hD;

   // Default frame limits (bytes, DA through FCS) and preamble minimum.
   localparam int DEF_MAX_LEN = 1518;
   localparam int DEF_MIN_LEN = 64;
   localparam int DEF_MIN_PRE = 2;

   // Byte counter saturation value.
   localparam logic [10:0] LEN_SAT = 11'd2047;

endpackage

// File: rtl/mii_rx_mac_if.sv
// Bus bundle between the MII PHY receive path, the MAC and the packet layer.
// Push-only stream, no back-pressure: o_data is taken by the sink on every
// cycle o_valid=1 (o_sof marks the first byte of a frame); o_eof is a one
// cycle strobe and o_frame_ok/o_err/o_len are meaningful only while it is high.
interface mii_rx_mac_if;
   import mii_rx_pkg::*;

   logic [3:0]  i_mii_rx_data;
   logic        i_mii_rx_dv;
   logic [7:0]  o_data;
   logic        o_valid;
   logic        o_sof;
   logic        o_eof;
   logic        o_frame_ok;
   logic [3:0]  o_err;
   logic [10:0] o_len;
   state_e      dbg_state;

   modport master (
      input  i_mii_rx_data, i_mii_rx_dv,
      output o_data, o_valid, o_sof, o_eof, o_frame_ok, o_err, o_len, dbg_state
   );

   modport slave (
      output i_mii_rx_data, i_mii_rx_dv,
      input  o_data, o_valid, o_sof, o_eof, o_frame_ok, o_err, o_len, dbg_state
   );
endinterface

// File: rtl/crc32_d8.sv
// Combinational next-state of the reflected CRC-32 for one input byte,
// LSB first. Shared with the transmit FCS generator.
module crc32_d8
   import mii_rx_pkg::*;
(
   input  logic [31:0] i_crc,
   input  logic [7:0]  i_data,
   output logic [31:0] o_crc
);

   logic [31:0] crc_v;

   // Eight serial shift/xor steps, byte folded into the low bits first.
   always_comb begin
      crc_v = i_crc ^ {24'h0, i_data};
      for (int i = 0; i < 8; i++) begin
         crc_v = crc_v[0] ? ((crc_v >> 1) ^ CRC_POLY) : (crc_v >> 1);
      end
      o_crc = crc_v;
   end

endmodule

// File: rtl/mii_rx_mac.sv
// MII receive MAC front end: preamble/SFD detection, nibble-to-byte assembly
// (low nibble first), CRC-32 check, length count and error classification.
// Optional build macro MII_RX_FCS_STRIP_EN: hold bytes in a 4-byte delay line
// so the FCS is never emitted on o_valid (status still covers the FCS).
module mii_rx_mac
   import mii_rx_pkg::*;
#(
   parameter int MAX_LEN = DEF_MAX_LEN,
   parameter int MIN_LEN = DEF_MIN_LEN,
   parameter int MIN_PRE = DEF_MIN_PRE
) (
   input logic           i_clk,
   input logic           i_res,
   mii_rx_mac_if.master  bus
);

   localparam logic [10:0] MAX_LEN_L = 11'(MAX_LEN);
   localparam logic [10:0] MIN_LEN_L = 11'(MIN_LEN);
   localparam logic [3:0]  MIN_PRE_L = 4'(MIN_PRE);

   state_e      state_q, state_d;
   logic [3:0]  pre_cnt_q, pre_cnt_d;
   logic        phase_q, phase_d;
   logic [3:0]  low_q, low_d;
   logic [10:0] cnt_q, cnt_d;
   logic [31:0] crc_q, crc_d;
   logic        first_q, first_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        sof_q, sof_d;
   logic        eof_q, eof_d;
   logic        ok_q, ok_d;
   logic [3:0]  err_q, err_d;
   logic [10:0] len_q, len_d;
   logic [3:0]  err_v;
   logic [7:0]  byte_w;
   logic [31:0] crc_next;
`ifdef MII_RX_FCS_STRIP_EN
   // Index of the byte leaving the delay line is cnt_q-4.
   localparam logic [10:0] EMIT_LIM = 11'(MAX_LEN + 4);
   logic [31:0] dly_q, dly_d;
   logic [2:0]  fill_q, fill_d;
`endif

   assign byte_w = {bus.i_mii_rx_data, low_q};

   crc32_d8 u_crc (
      .i_crc  (crc_q),
      .i_data (byte_w),
      .o_crc  (crc_next)
   );

   // Next-state, byte assembly, emission and end-of-frame status.
   always_comb begin
      state_d   = state_q;
      pre_cnt_d = pre_cnt_q;
      phase_d   = phase_q;
      low_d     = low_q;
      cnt_d     = cnt_q;
      crc_d     = crc_q;
      first_d   = first_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      sof_d     = 1'b0;
      eof_d     = 1'b0;
      ok_d      = 1'b0;
      err_d     = 4'h0;
      len_d     = 11'd0;
      err_v     = 4'h0;
`ifdef MII_RX_FCS_STRIP_EN
      dly_d     = dly_q;
      fill_d    = fill_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.i_mii_rx_dv) begin
               if (bus.i_mii_rx_data == NIB_PRE) begin
                  state_d   = ST_PRE;
                  pre_cnt_d = 4'd1;
               end else begin
                  state_d = ST_DROP;
               end
            end
         end
         ST_PRE: begin
            if (!bus.i_mii_rx_dv) begin
               state_d = ST_IDLE;
            end else if (bus.i_mii_rx_data == NIB_PRE) begin
               pre_cnt_d = (pre_cnt_q == 4'hF) ? pre_cnt_q : pre_cnt_q + 4'd1;
            end else if (bus.i_mii_rx_data == NIB_SFD && pre_cnt_q >= MIN_PRE_L) begin
               state_d = ST_DATA;
               phase_d = 1'b0;
               cnt_d   = 11'd0;
               crc_d   = CRC_INIT;
               first_d = 1'b1;
`ifdef MII_RX_FCS_STRIP_EN
               dly_d   = 32'h0;
               fill_d  = 3'd0;
`endif
            end else begin
               state_d = ST_DROP;
            end
         end
         ST_DATA: begin
            if (!bus.i_mii_rx_dv) begin
               // A pending low nibble means the frame was not byte aligned.
               err_v[ERR_CRC]   = (crc_q != CRC_RESIDUE);
               err_v[ERR_RUNT]  = (cnt_q < MIN_LEN_L);
               err_v[ERR_LONG]  = (cnt_q > MAX_LEN_L);
               err_v[ERR_ALIGN] = phase_q;
               eof_d   = 1'b1;
               err_d   = err_v;
               ok_d    = (err_v == 4'h0);
               len_d   = cnt_q;
               state_d = ST_IDLE;
            end else if (!phase_q) begin
               low_d   = bus.i_mii_rx_data;
               phase_d = 1'b1;
            end else begin
               phase_d = 1'b0;
               crc_d   = crc_next;
               cnt_d   = (cnt_q == LEN_SAT) ? cnt_q : cnt_q + 11'd1;
`ifdef MII_RX_FCS_STRIP_EN
               dly_d = {dly_q[23:0], byte_w};
               if (fill_q == 3'd4) begin
                  if (cnt_q < EMIT_LIM) begin
                     valid_d = 1'b1;
                     data_d  = dly_q[31:24];
                     sof_d   = first_q;
                     first_d = 1'b0;
                  end
               end else begin
                  fill_d = fill_q + 3'd1;
               end
`else
               if (cnt_q < MAX_LEN_L) begin
                  valid_d = 1'b1;
                  data_d  = byte_w;
                  sof_d   = first_q;
                  first_d = 1'b0;
               end
`endif
            end
         end
         ST_DROP: begin
            if (!bus.i_mii_rx_dv) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers; reset aborts any frame without an o_eof.
   always_ff @(posedge i_clk or posedge i_res) begin
      if (i_res) begin
         state_q   <= ST_IDLE;
         pre_cnt_q <= 4'd0;
         phase_q   <= 1'b0;
         low_q     <= 4'd0;
         cnt_q     <= 11'd0;
         crc_q     <= CRC_INIT;
         first_q   <= 1'b0;
         data_q    <= 8'd0;
         valid_q   <= 1'b0;
         sof_q     <= 1'b0;
         eof_q     <= 1'b0;
         ok_q      <= 1'b0;
         err_q     <= 4'd0;
         len_q     <= 11'd0;
`ifdef MII_RX_FCS_STRIP_EN
         dly_q     <= 32'h0;
         fill_q    <= 3'd0;
`endif
      end else begin
         state_q   <= state_d;
         pre_cnt_q <= pre_cnt_d;
         phase_q   <= phase_d;
         low_q     <= low_d;
         cnt_q     <= cnt_d;
         crc_q     <= crc_d;
         first_q   <= first_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         sof_q     <= sof_d;
         eof_q     <= eof_d;
         ok_q      <= ok_d;
         err_q     <= err_d;
         len_q     <= len_d;
`ifdef MII_RX_FCS_STRIP_EN
         dly_q     <= dly_d;
         fill_q    <= fill_d;
`endif
      end
   end

   assign bus.o_data     = data_q;
   assign bus.o_valid    = valid_q;
   assign bus.o_sof      = sof_q;
   assign bus.o_eof      = eof_q;
   assign bus.o_frame_ok = ok_q;
   assign bus.o_err      = err_q;
   assign bus.o_len      = len_q;
   assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_mii_rx_mac.sv
// Bench for mii_rx_mac: table of frame vectors driven back to back with a
// one-cycle dv gap, a byte/status scoreboard, and a mid-frame reset sequence.
module tb_mii_rx_mac;

   typedef struct {
      int         len;        // frame bytes DA..FCS
      int         flip;       // byte index whose bit 3 is flipped, -1 none
      bit         extra;      // one trailing odd nibble
      int         pre_n;      // 0x5 nibbles before 0xD
      bit         bad;        // preamble nibble 3 replaced by 0x7
      bit         exp_eof;
      int         exp_valid;  // o_valid strobes, FCS emitted
      int         exp_valid_s;// o_valid strobes, FCS stripped
      logic [3:0] exp_err;
      int         exp_len;
   } vec_t;

   typedef struct {
      logic       ok;
      logic [3:0] err;
      logic [10:0] len;
      int         nvalid;
      bit         chk_gap;
   } st_t;

`ifdef MII_RX_FCS_STRIP_EN
   localparam bit STRIP = 1'b1;
`else
   localparam bit STRIP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #20 clk = ~clk;

   mii_rx_mac_if bus ();
   mii_rx_mac dut (.i_clk(clk), .i_res(rst), .bus(bus));

   logic [8:0] exp_q[$];
   st_t        st_q[$];
   vec_t       vecs[12];
   int n_vec = 0;
   int n_miss = 0;
   int cyc = 0;
   int eof_seen = 0;
   int nvalid_cnt = 0;
   int last_valid_cyc = 0;
   bit mon_en = 1'b0;

   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++)
         r = (r[0] ^ b[i]) ? ({1'b0, r[31:1]} ^ 32'hEDB88320) : {1'b0, r[31:1]};
      return r;
   endfunction

   task automatic drive_nib(input logic [3:0] n);
      @(negedge clk);
      bus.i_mii_rx_dv   = 1'b1;
      bus.i_mii_rx_data = n;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.i_mii_rx_dv   = 1'b0;
         bus.i_mii_rx_data = 4'h0;
      end
   endtask

   task automatic run_vec(input vec_t v);
      logic [7:0]  frm[$];
      logic [7:0]  b;
      logic [31:0] c;
      int          nv;
      st_t         s;
      c = 32'hFFFFFFFF;
      for (int k = 0; k < v.len - 4; k++) begin
         b = 8'($urandom_range(0, 255));
         frm.push_back(b);
         c = crc_upd(c, b);
      end
      c = ~c;
      for (int k = 0; k < 4; k++) frm.push_back(c[8*k +: 8]);
      if (v.flip >= 0) frm[v.flip] = frm[v.flip] ^ 8'h08;
      nv = STRIP ? v.exp_valid_s : v.exp_valid;
      if (v.exp_eof) begin
         for (int k = 0; k < nv; k++) exp_q.push_back({(k == 0), frm[k]});
         s.ok      = (v.exp_err == 4'h0);
         s.err     = v.exp_err;
         s.len     = 11'(v.exp_len);
         s.nvalid  = nv;
         s.chk_gap = !v.extra && (v.len <= 1518) && (nv > 0);
         st_q.push_back(s);
      end
      for (int k = 0; k < v.pre_n; k++) drive_nib((v.bad && k == 3) ? 4'h7 : 4'h5);
      drive_nib(4'hD);
      for (int k = 0; k < v.len; k++) begin
         drive_nib(frm[k][3:0]);
         drive_nib(frm[k][7:4]);
      end
      if (v.extra) drive_nib(4'($urandom_range(0, 15)));
      idle(1);
   endtask

   task automatic check_empty(input string tag);
      n_vec++;
      if (exp_q.size() != 0 || st_q.size() != 0) begin
         n_miss++;
         $display("FAIL %s: pending bytes=%0d status=%0d, want 0/0", tag, exp_q.size(), st_q.size());
      end
   endtask

   // Scoreboard: compares every byte strobe and every end-of-frame status.
   initial begin
      st_t s;
      logic [8:0] e;
      forever begin
         @(negedge clk);
         cyc++;
         if (bus.o_eof) eof_seen++;
         if (mon_en && bus.o_valid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_miss++;
               $display("FAIL byte_extra: got data=%h sof=%0b, want no byte", bus.o_data, bus.o_sof);
            end else begin
               e = exp_q.pop_front();
               if ({bus.o_sof, bus.o_data} !== e) begin
                  n_miss++;
                  $display("FAIL byte: got sof=%0b data=%h, want sof=%0b data=%h",
                           bus.o_sof, bus.o_data, e[8], e[7:0]);
               end
            end
            nvalid_cnt++;
            last_valid_cyc = cyc;
         end
         if (mon_en && bus.o_eof) begin
            n_vec++;
            if (st_q.size() == 0) begin
               n_miss++;
               $display("FAIL eof_extra: got eof err=%b len=%0d, want no eof", bus.o_err, bus.o_len);
            end else begin
               s = st_q.pop_front();
               if (bus.o_frame_ok !== s.ok || bus.o_err !== s.err || bus.o_len !== s.len ||
                   nvalid_cnt != s.nvalid) begin
                  n_miss++;
                  $display("FAIL status: got ok=%0b err=%b len=%0d nvalid=%0d, want ok=%0b err=%b len=%0d nvalid=%0d",
                           bus.o_frame_ok, bus.o_err, bus.o_len, nvalid_cnt, s.ok, s.err, s.len, s.nvalid);
               end
               if (s.chk_gap) begin
                  n_vec++;
                  if (cyc - last_valid_cyc != 1) begin
                     n_miss++;
                     $display("FAIL eof_gap: got %0d cycles after last byte, want 1", cyc - last_valid_cyc);
                  end
               end
            end
            nvalid_cnt = 0;
         end
      end
   end

   initial begin
      int e0;
      vecs[0]  = '{64,   -1, 0, 15, 0, 1, 64,   60,   4'h0, 64};
      vecs[1]  = '{64,   10, 0, 15, 0, 1, 64,   60,   4'h1, 64};
      vecs[2]  = '{40,   -1, 0, 15, 0, 1, 40,   36,   4'h2, 40};
      vecs[3]  = '{64,   -1, 1, 15, 0, 1, 64,   60,   4'h8, 64};
      vecs[4]  = '{1600, -1, 0, 15, 0, 1, 1518, 1518, 4'h4, 1600};
      vecs[5]  = '{64,   -1, 0, 15, 1, 0, 0,    0,    4'h0, 0};
      vecs[6]  = '{64,   -1, 0, 1,  0, 0, 0,    0,    4'h0, 0};
      vecs[7]  = '{64,   -1, 0, 2,  0, 1, 64,   60,   4'h0, 64};
      vecs[8]  = '{63,   -1, 0, 15, 0, 1, 63,   59,   4'h2, 63};
      vecs[9]  = '{1518, -1, 0, 15, 0, 1, 1518, 1514, 4'h0, 1518};
      vecs[10] = '{1519, -1, 0, 15, 0, 1, 1518, 1515, 4'h4, 1519};
      vecs[11] = '{4,    -1, 0, 15, 0, 1, 4,    0,    4'h2, 4};

      bus.i_mii_rx_dv   = 1'b0;
      bus.i_mii_rx_data = 4'h0;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      n_vec++;
      if ({bus.o_data, bus.o_valid, bus.o_sof, bus.o_eof, bus.o_frame_ok, bus.o_err, bus.o_len} !== 27'd0) begin
         n_miss++;
         $display("FAIL reset_state: got data=%h v=%b s=%b e=%b ok=%b err=%b len=%0d, want all 0",
                  bus.o_data, bus.o_valid, bus.o_sof, bus.o_eof, bus.o_frame_ok, bus.o_err, bus.o_len);
      end
      rst    = 1'b0;
      mon_en = 1'b1;
      idle(2);

      foreach (vecs[i]) run_vec(vecs[i]);
      idle(8);
      check_empty("table_drain");

      // Reset in the middle of a frame: outputs clear at once, no o_eof.
      mon_en = 1'b0;
      e0 = eof_seen;
      for (int k = 0; k < 15; k++) drive_nib(4'h5);
      drive_nib(4'hD);
      for (int k = 0; k < 30; k++) begin
         drive_nib(4'hA);
         drive_nib(4'h5);
      end
      @(posedge clk);
      #5 rst = 1'b1;
      #1;
      n_vec++;
      if ({bus.o_data, bus.o_valid, bus.o_sof, bus.o_eof, bus.o_frame_ok, bus.o_err, bus.o_len} !== 27'd0) begin
         n_miss++;
         $display("FAIL midframe_reset: got data=%h v=%b eof=%b len=%0d, want all 0",
                  bus.o_data, bus.o_valid, bus.o_eof, bus.o_len);
      end
      idle(2);
      rst = 1'b0;
      idle(4);
      n_vec++;
      if (eof_seen != e0) begin
         n_miss++;
         $display("FAIL reset_no_eof: got %0d eof strobes, want 0", eof_seen - e0);
      end
      nvalid_cnt = 0;
      mon_en     = 1'b1;

      run_vec(vecs[0]);
      run_vec(vecs[2]);
      idle(8);
      check_empty("final_drain");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
